// File: rtl/cmp_stream_stage.sv
// cmp_stream_stage: two-stage valid/ready comparator pipeline with a saturating hit counter.
// Optional sticky run alarm enabled by defining CMP_RUN_ALARM_EN.
module cmp_stream_stage #(
    parameter int N      = 8,
    parameter int CW     = 16,
    parameter int RUN_TH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    sel,
    input  logic [N-1:0]  value1,
    input  logic [N-1:0]  value2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_result,
    output logic [CW-1:0] hit_count,
    input  logic          clr_count,
    output logic          alarm
);
    logic          s1_valid_q, s1_valid_d;
    logic [2:0]    sel_q, sel_d;
    logic [N-1:0]  v1_q, v1_d, v2_q, v2_d;
    logic          s2_valid_q, s2_valid_d;
    logic          res_q, res_d;
    logic [CW-1:0] hit_q, hit_d;
    logic          adv1, adv2, in_xfer, out_xfer, eval;

    always_comb begin
        case (sel_q)
            3'd0:    eval = 1'b0;
            3'd1:    eval = 1'b1;
            3'd2:    eval = v1_q == v2_q;
            3'd3:    eval = v1_q != v2_q;
            3'd4:    eval = v1_q >= v2_q;
            3'd5:    eval = v1_q <= v2_q;
            3'd6:    eval = v1_q < v2_q;
            default: eval = v1_q > v2_q;
        endcase
    end

    always_comb begin
        adv2       = !s2_valid_q || out_ready;
        adv1       = s1_valid_q && adv2;
        in_ready   = !s1_valid_q || adv2;
        in_xfer    = in_valid && in_ready;
        out_xfer   = s2_valid_q && out_ready;
        s1_valid_d = in_xfer || (s1_valid_q && !adv1);
        sel_d      = in_xfer ? sel : sel_q;
        v1_d       = in_xfer ? value1 : v1_q;
        v2_d       = in_xfer ? value2 : v2_q;
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        res_d      = adv1 ? eval : res_q;
        hit_d      = clr_count ? '0 :
                     (out_xfer && res_q && hit_q != {CW{1'b1}}) ? hit_q + CW'(1) : hit_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            sel_q      <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= 1'b0;
            hit_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            sel_q      <= sel_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            hit_q      <= hit_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = res_q;
    assign hit_count  = hit_q;

`ifdef CMP_RUN_ALARM_EN
    logic [CW-1:0] run_q, run_d;
    logic          alarm_q, alarm_d;

    // a false result breaks the run; the alarm latches once the run hits RUN_TH
    always_comb begin
        run_d   = clr_count ? '0 :
                  !out_xfer ? run_q :
                  !res_q ? '0 :
                  (run_q == {CW{1'b1}}) ? run_q : run_q + CW'(1);
        alarm_d = !clr_count && (alarm_q || run_d == CW'(RUN_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    localparam int unused_run_th = RUN_TH;
    assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_cmp_stream_stage.sv
// tb_cmp_stream_stage: directed checks of cmp_stream_stage, with a CW=2 twin for saturation.
module tb_cmp_stream_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic [7:0]  value1 = 8'd0, value2 = 8'd0;
    logic        out_ready = 1'b0;
    logic        clr_count = 1'b0;
    logic        in_ready, out_valid, out_result, alarm;
    logic [15:0] hit_count;
    logic        in_ready_s, out_valid_s, out_result_s, alarm_s;
    logic [1:0]  hit_count_s;
    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_vec = 8'b0110_1010;
    logic        alarm_en;

    cmp_stream_stage #(.N(8), .CW(16), .RUN_TH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .value1(value1), .value2(value2), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .hit_count(hit_count), .clr_count(clr_count), .alarm(alarm)
    );

    cmp_stream_stage #(.N(8), .CW(2), .RUN_TH(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .sel(sel),
        .value1(value1), .value2(value2), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_result(out_result_s), .hit_count(hit_count_s), .clr_count(clr_count), .alarm(alarm_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef CMP_RUN_ALARM_EN
        alarm_en = 1'b1;
`else
        alarm_en = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_hit", 32'(hit_count), 0);
        check("rst_alarm", 32'(alarm), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // single tuple, equality
        in_valid = 1'b1; sel = 3'd2; value1 = 8'h5A; value2 = 8'h5A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_lat_early", 32'(out_valid), 0);
        tick();
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_result", 32'(out_result), 1);
        tick();
        check("t1_hit", 32'(hit_count), 1);
        check("t1_drained", 32'(out_valid), 0);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_hit", 32'(hit_count), 0);

        // all eight ops back to back, 3 vs 7
        value1 = 8'd3; value2 = 8'd7;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            sel = 3'(i);
            tick();
            if (i >= 1 && i <= 8) begin
                check($sformatf("t2_valid_%0d", i - 1), 32'(out_valid), 1);
                check($sformatf("t2_res_sel%0d", i - 1), 32'(out_result), 32'(exp_vec[i - 1]));
            end
        end
        check("t2_drained", 32'(out_valid), 0);
        check("t2_hit", 32'(hit_count), 4);
        check("t2_hit_sat", 32'(hit_count_s), 3);

        // backpressure: two tuples buffered, third stalls
        out_ready = 1'b0; value1 = 8'd1; value2 = 8'd2;
        in_valid = 1'b1; sel = 3'd1;
        check("t3_rdy_a", 32'(in_ready), 1);
        tick();
        sel = 3'd0;
        check("t3_rdy_b", 32'(in_ready), 1);
        tick();
        sel = 3'd3;
        check("t3_full_valid", 32'(out_valid), 1);
        check("t3_full_res", 32'(out_result), 1);
        check("t3_rdy_c", 32'(in_ready), 0);
        tick();
        check("t3_hold_valid", 32'(out_valid), 1);
        check("t3_hold_res", 32'(out_result), 1);
        check("t3_hold_rdy", 32'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        check("t3_rdy_comb", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("t3_res_b", 32'(out_result), 0);
        tick();
        check("t3_res_c", 32'(out_result), 1);
        tick();
        check("t3_drained", 32'(out_valid), 0);
        check("t3_hit", 32'(hit_count), 6);

        // saturation of the CW=2 twin, then clear racing a true transfer
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        sel = 3'd1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            tick();
        end
        check("t4_hit", 32'(hit_count), 5);
        check("t4_hit_sat", 32'(hit_count_s), 3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t4_clr_pending", 32'(out_valid), 1);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("t4_clr_hit", 32'(hit_count), 0);
        check("t4_clr_hit_sat", 32'(hit_count_s), 0);
        check("t4_clr_xfer", 32'(out_valid), 0);

        // run alarm: T T T F T T T T F F
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10);
            sel = (i == 3 || i >= 8) ? 3'd0 : 3'd1;
            tick();
            check($sformatf("t5_alarm_%0d", i), 32'(alarm), 32'(alarm_en && i >= 9));
        end
        check("t5_hit", 32'(hit_count), 7);

        // async reset with two tuples buffered
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
        tick();
        tick();
        in_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_async_flush", 32'(out_valid), 0);
        #10;
        rst = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_rdy", 32'(in_ready), 1);
        check("t6_hit", 32'(hit_count), 0);
        check("t6_alarm", 32'(alarm), 0);
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_no_stale", 32'(out_valid), 0);

        // clear coinciding with the transfer that reaches the threshold
        sel = 3'd1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4);
            clr_count = (i == 5);
            tick();
        end
        clr_count = 1'b0;
        check("t7_alarm", 32'(alarm), 0);
        check("t7_hit", 32'(hit_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
